// File: rtl/prbs18_pkg.sv
// Shared PRBS18 definitions: LFSR geometry, checker FSM encoding and the
// next-state function used by both the generator and the checker.
package prbs18_pkg;

    localparam int STATE_W = 18;
    localparam int TAP_A   = 17;
    localparam int TAP_B   = 10;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    // The AND term breaks the all-ones lockup of the XNOR feedback.
    function automatic logic [STATE_W-1:0] lfsr18_next(input logic [STATE_W-1:0] s);
        logic fb;
        fb = (s[TAP_A] ~^ s[TAP_B]) ^ (&s[STATE_W-2:0]);
        return {s[STATE_W-2:0], fb};
    endfunction

endpackage

// File: rtl/prbs18_rx_checker_if.sv
// Byte stream in / status out bundle for the PRBS18 checker.
// range_count exists only when PRBS18_RANGE_STAT_EN is defined.
interface prbs18_rx_checker_if #(parameter int CNT_W = 16);

    logic [7:0]       in_data;
    logic             in_en;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sample_count;
    logic [1:0]       state_o;
`ifdef PRBS18_RANGE_STAT_EN
    logic [CNT_W-1:0] range_count;

    modport master (output in_data, in_en, clr_cnt,
                    input  locked, err_pulse, err_count, sample_count, state_o, range_count);
    modport slave  (input  in_data, in_en, clr_cnt,
                    output locked, err_pulse, err_count, sample_count, state_o, range_count);
`else
    modport master (output in_data, in_en, clr_cnt,
                    input  locked, err_pulse, err_count, sample_count, state_o);
    modport slave  (input  in_data, in_en, clr_cnt,
                    output locked, err_pulse, err_count, sample_count, state_o);
`endif

endinterface

// File: rtl/prbs18_sat_counter.sv
// Saturating up-counter; clear beats increment.
module prbs18_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + ONE;
    end

    assign o_count = r_count;

endmodule

// File: rtl/prbs18_rx_checker.sv
// PRBS18 receive checker: seeds a predictor from 18 received bits, verifies,
// locks and counts mismatches. PRBS18_RANGE_STAT_EN adds the range_count statistic.
module prbs18_rx_checker
    import prbs18_pkg::*;
#(
    parameter int         LOCK_THRESH = 32,
    parameter int         RESYNC_ERRS = 8,
    parameter int         CNT_W       = 16,
    parameter logic [7:0] LOW         = 8'd90,
    parameter logic [7:0] HIGH        = 8'd128
) (
    input logic                clk,
    input logic                rst,
    prbs18_rx_checker_if.slave i_bus
);

    prbs_state_e        r_state;
    logic [STATE_W-1:0] r_pred;
    logic [4:0]         r_seed_cnt;
    logic [7:0]         r_match_cnt;
    logic [7:0]         r_mis_cnt;
    logic               r_locked;
    logic               r_err_pulse;

    logic               w_mis;
    logic               w_lk_byte;
    logic [STATE_W-1:0] w_shift;
    logic [CNT_W-1:0]   w_err_count;
    logic [CNT_W-1:0]   w_sample_count;

    assign w_shift   = {r_pred[STATE_W-2:0], i_bus.in_data[0]};
    assign w_mis     = (i_bus.in_data != r_pred[7:0]);
    assign w_lk_byte = i_bus.in_en && (r_state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEED;
            r_pred      <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_mis_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_lk_byte && w_mis;
            if (i_bus.in_en) begin
                case (r_state)
                    ST_SEED: begin
                        // Predictor now holds the generator state; step it to the next byte.
                        if (r_seed_cnt == 5'(STATE_W-1)) begin
                            r_pred      <= lfsr18_next(w_shift);
                            r_seed_cnt  <= '0;
                            r_match_cnt <= '0;
                            r_state     <= ST_CHECK;
                        end else begin
                            r_pred     <= w_shift;
                            r_seed_cnt <= r_seed_cnt + 5'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (w_mis) begin
                            r_pred      <= w_shift;
                            r_seed_cnt  <= 5'd1;
                            r_match_cnt <= '0;
                            r_state     <= ST_SEED;
                        end else begin
                            r_pred <= lfsr18_next(r_pred);
                            if (r_match_cnt == 8'(LOCK_THRESH-1)) begin
                                r_match_cnt <= '0;
                                r_mis_cnt   <= '0;
                                r_locked    <= 1'b1;
                                r_state     <= ST_LOCKED;
                            end else begin
                                r_match_cnt <= r_match_cnt + 8'd1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        r_pred <= lfsr18_next(r_pred);
                        if (!w_mis) begin
                            r_mis_cnt <= '0;
                        end else if (r_mis_cnt == 8'(RESYNC_ERRS-1)) begin
                            r_mis_cnt  <= '0;
                            r_seed_cnt <= '0;
                            r_locked   <= 1'b0;
                            r_state    <= ST_SEED;
                        end else begin
                            r_mis_cnt <= r_mis_cnt + 8'd1;
                        end
                    end
                    default: r_state <= ST_SEED;
                endcase
            end
        end
    end

    prbs18_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_lk_byte && w_mis),
        .i_clr   (i_bus.clr_cnt),
        .o_count (w_err_count)
    );

    prbs18_sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_lk_byte),
        .i_clr   (i_bus.clr_cnt),
        .o_count (w_sample_count)
    );

`ifdef PRBS18_RANGE_STAT_EN
    logic             w_in_range;
    logic [CNT_W-1:0] w_range_count;

    assign w_in_range = (i_bus.in_data >= LOW) && (i_bus.in_data <= HIGH);

    prbs18_sat_counter #(.CNT_W(CNT_W)) u_range_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_lk_byte && w_in_range),
        .i_clr   (i_bus.clr_cnt),
        .o_count (w_range_count)
    );

    assign i_bus.range_count = w_range_count;
`endif

    assign i_bus.locked       = r_locked;
    assign i_bus.err_pulse    = r_err_pulse;
    assign i_bus.err_count    = w_err_count;
    assign i_bus.sample_count = w_sample_count;
    assign i_bus.state_o      = r_state;

endmodule

// File: doc/prbs18_rx_checker.md
Name: prbs18_rx_checker

Overview:
- Receive-side checker for the 18-bit LFSR random-byte stream generated elsewhere in the design.
- Reconstructs the generator state from incoming bytes, locks to the sequence, then predicts every following byte.
- Flags and counts mismatches so link, FIFO and datapath integrity can be verified on-board.
- Sits at the sink end of any path the random stream traverses.

Parameters:
- LOCK_THRESH, 32: consecutive correct predictions required in CHECK before declaring lock (1..255).
- RESYNC_ERRS, 8: consecutive mismatches in LOCKED that force re-seeding (1..255).
- CNT_W, 16: width of the error and sample counters.
- LOW, 8'd90: lower bound of the range-statistic window (inclusive).
- HIGH, 8'd128: upper bound of the range-statistic window (inclusive).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  8  received byte, equal to generator state[7:0].
- in_en  in  1  in_data valid this cycle; the checker advances only on in_en=1.
- clr_cnt  in  1  synchronous clear of all counters; does not affect lock state.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched byte while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.
- sample_count  out  CNT_W  saturating count of in_en bytes seen while LOCKED.
- state_o  out  2  FSM state: 0 SEED, 1 CHECK, 2 LOCKED.

Behaviour:
- LFSR model is identical to the generator, 18-bit state s.
  - Next s[17:1] = s[16:0].
  - Next s[0] = (s[17] XNOR s[10]) XOR (AND of s[16:0]).
  - Byte observed = s[7:0].
- Reset: FSM=SEED, seed counter=0, predictor=0, all outputs 0.
- SEED: on each in_en, shift in_data[0] into predictor bit 0 (predictor[17:1] <= predictor[16:0]) and increment seed counter.
  - After the 18th in_en byte, the predictor equals the generator state. Advance predictor once, then go to CHECK.
- CHECK: on each in_en, compare in_data with predictor[7:0], then advance predictor.
  - On a match, increment the match counter. When it reaches LOCK_THRESH, go to LOCKED.
  - On any mismatch, clear the match counter and seed counter and return to SEED. The mismatched byte counts as seed byte 1.
- LOCKED: on each in_en, compare and advance the predictor. The predictor free-runs and is never reloaded from in_data.
  - sample_count increments on every in_en byte.
  - On a mismatch: err_pulse=1 in the following cycle (registered, 1-cycle latency) and err_count increments. Both counters saturate at all-ones.
  - A consecutive-mismatch counter clears on any match. When it reaches RESYNC_ERRS, go to SEED, drop locked, and clear the seed counter. Counters are retained.
- in_en=0: no state, counter or predictor change in any state.
- clr_cnt=1: err_count, sample_count and the range counter go to 0. If in_en is also high with an error that cycle, clear wins (count = 0, not 1).
- locked and state_o are registered and update the cycle after the transition-causing byte.
- rst mid-operation returns to the reset values above on the next edge.

Optional Feature:
- Macro: PRBS18_RANGE_STAT_EN.
- Defined: adds output range_count (CNT_W, saturating). It increments on every in_en byte while LOCKED with LOW <= in_data <= HIGH, matching the generator's valid window, and clears with clr_cnt and rst.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package prbs18_pkg holds:
  - STATE_W=18, TAP_A=17, TAP_B=10;
  - the FSM state encoding (SEED/CHECK/LOCKED);
  - a function lfsr18_next(state) reused by generator-side and checker-side code.
- Sub-module prbs18_sat_counter: CNT_W saturating counter with inc/clr inputs; clr has priority. Instantiated for err_count, sample_count and range_count.

Test Plan:
- Generator model, seed 3, in_en=1 continuously: bytes 0x03,0x07,0x0F,0x1F,0x3F,0x7F,0xFF,... -> CHECK after 18 bytes; locked=1 one cycle after byte 18+32; err_count=0.
- After lock, corrupt one byte (XOR 0x01) -> one err_pulse one cycle later; err_count=1; locked stays 1; subsequent bytes match.
- After lock, corrupt 8 consecutive bytes -> locked=0 after the 8th; FSM re-seeds and relocks after 18+32 clean bytes; err_count=8.
- Random in_en gaps (about 50% duty) -> lock timing counted in in_en bytes only; no errors.
- clr_cnt asserted in the same cycle as an erroring byte -> err_count=0 next cycle.
- With PRBS18_RANGE_STAT_EN: lock, run 1000 bytes -> range_count equals the number of bytes in 90..128 from the reference model.
